dpram_be: RTL and testbench
===========================

DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: word width in bits, a multiple of 8, range 8..128.
REQ-002 SHALL provide parameter DEPTH, default 1024: number of words, a power of two, range 16..65536.
REQ-003 SHALL provide parameter ADDR_W, default 32: width of the byte address.
REQ-004 SHALL provide parameter INIT_WORD, default 32'h00000013 (NOP), truncated or zero-extended to DATA_W: fill value loaded after reset.
REQ-005 SHALL have a single clock and a synchronous active-low reset:
- m_clock  in  1  sole clock; all state updates on its rising edge.
- p_reset  in  1  synchronous, active-low reset; sampled only on the m_clock edge.
REQ-006 SHALL provide, per port n = 1, 2:
- reqn  in  1  access request.
- wen  in  1  1 = write, 0 = read; valid only with reqn.
- ben  in  DATA_W/8  byte enables for writes.
- addrn  in  ADDR_W  byte address.
- wdatan  in  DATA_W  write data.
- rdatan  out  DATA_W  registered read data.
- rvalidn  out  1  read-response pulse.
- errn  out  1  misalignment-error pulse.
REQ-007 SHALL provide busy  out  1: initialisation in progress; requests ignored.

Function
REQ-008 SHALL use the following address mapping, with B = DATA_W/8:
- addrn[log2(B)-1:0] is the byte offset.
- The next log2(DEPTH) bits form the word index.
- Higher address bits are ignored, so addresses wrap modulo DEPTH*B.
REQ-009 SHALL treat an access as misaligned when reqn=1 and the byte offset is nonzero.
- A misaligned access writes nothing.
- The cycle after it, errn=1, rvalidn=0 and rdatan=0.
REQ-010 SHALL complete an aligned read with reqn=1, wen=0 at cycle N as follows:
- At N+1, rdatan = word contents and rvalidn=1 for exactly one cycle.
- Read latency is fixed at 1.
REQ-011 SHALL hold rdatan after a read until the next read or error response on that port.
REQ-012 SHALL perform an aligned write with reqn=1, wen=1 as follows:
- Each byte lane i with ben[i]=1 updates at the clock edge; other lanes are unchanged.
- No rvalidn or errn is generated.
REQ-013 SHALL accept a new request on each port every cycle; there is no back-pressure except busy.
REQ-014 SHALL give an old-data (read-first) result when one port reads a word that the other port writes in the same cycle.
REQ-015 SHALL resolve both ports writing the same word in the same cycle per byte:
- Lanes enabled on both ports take port-1 data.
- Lanes enabled only on port 2 take port-2 data.
REQ-016 SHALL handle port 1 and port 2 independently in all other cases, with no ordering between them.
REQ-017 SHALL implement a two-state FSM with states INIT and READY.
REQ-018 SHALL, in INIT, write INIT_WORD to word index cnt at each edge, with cnt counting 0..DEPTH-1, and drive busy=1.
REQ-019 SHALL move from INIT to READY on the edge that writes index DEPTH-1; busy=0 from the following cycle, so INIT lasts exactly DEPTH cycles.
REQ-020 SHALL, while busy=1, ignore reqn on both ports: no write, and no rvalidn or errn.
REQ-021 SHALL leave READY only by reset; there is no other transition out of READY.

Reset
REQ-022 SHALL, on p_reset=0 at an edge, set the following state:
- FSM = INIT, cnt = 0.
- rvalidn = 0, errn = 0, rdatan = 0, busy = 1.
REQ-023 SHALL hold these values for as long as p_reset=0, with no memory writes during that time.
REQ-024 SHALL restart initialisation from index 0 when reset is asserted mid-INIT or mid-operation.
REQ-025 SHALL begin initialisation on the first edge with p_reset=1.
REQ-026 SHALL have defined memory contents only after INIT completes; reset does not clear memory in zero time.

Verification (DATA_W=32, DEPTH=1024)
REQ-027 SHALL verify init: release reset -> busy=1 for exactly 1024 cycles, then 0; read port 1 at 0x0, 0xFFC and 0x1000 -> rdata1=0x00000013, rvalid1 one cycle later each.
REQ-028 SHALL verify byte enables: write port 1 addr 0x10, wdata 0xAABBCCDD, be 4'b0101; then read -> 0x00BB00DD.
REQ-029 SHALL verify same-word write collision: port 1 writes 0x20, data 0x11111111, be 4'b0011, while port 2 writes 0x20, data 0x22222222, be 4'b1110 in the same cycle; then read -> 0x22221111.
REQ-030 SHALL verify read-first across ports: port 1 writes 0x30 = 0xDEADBEEF while port 2 reads 0x30 in the same cycle -> rdata2=0x00000013; next read -> 0xDEADBEEF.
REQ-031 SHALL verify misalignment: port 2 read at 0x41 -> err2=1, rvalid2=0, rdata2=0 next cycle; port 2 write at 0x42 -> err2=1 and word 0x40 unchanged.
REQ-032 SHALL verify reset mid-INIT: assert p_reset=0 at cnt=500 for 2 cycles -> busy remains 1 and completes 1024 cycles after release; requests issued during busy produce no rvalid or err.

Source files
------------

// File: rtl/dpram_be_if.sv
// dpram_be_if -- one access port of the byte-enabled dual-port RAM.
//
// Signals (one instance per RAM port):
//   req    access request
//   we     1 = write, 0 = read (meaningful only with req)
//   be     byte enables for writes, one bit per byte lane
//   addr   byte address
//   wdata  write data
//   rdata  registered read data
//   rvalid one-cycle read-response pulse
//   err    one-cycle misalignment-error pulse
//
// Modports: master drives the request side, slave is the RAM side.
interface dpram_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/dpram_be.sv
// dpram_be -- dual-port RAM with per-byte write enables and self-initialisation.
//
// After reset the RAM walks every word index and writes INIT_WORD, holding
// busy high for exactly DEPTH cycles; requests are ignored meanwhile.
// Afterwards both ports accept one request per cycle with a fixed read
// latency of one cycle. Misaligned accesses write nothing and return an
// error pulse with zero read data.
//
// Ports:
//   m_clock  sole clock, rising edge
//   p_reset  synchronous active-low reset
//   p1, p2   access ports (dpram_be_if slave modport)
//   busy     initialisation in progress
module dpram_be #(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 1024,
  parameter int              ADDR_W    = 32,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic        m_clock,
  input  logic        p_reset,
  dpram_be_if.slave   p1,
  dpram_be_if.slave   p2,
  output logic        busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   cnt_reg, cnt_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    case (state_reg)
      INIT: begin
        busy     = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        // The edge that fills the last index also hands over to READY.
        if (cnt_reg == IDX_W'(DEPTH - 1)) state_next = READY;
      end
      READY: begin
        state_next = READY;
      end
      default: state_next = INIT;
    endcase
  end

  // ------------------------------------------------------ address decode
  logic [IDX_W-1:0] idx1, idx2;
  logic             mis1, mis2;

  assign idx1 = p1.addr[OFF_W +: IDX_W];
  assign idx2 = p2.addr[OFF_W +: IDX_W];

  // With byte-wide words there is no offset field, so nothing can misalign.
  if (OFF_W > 0) begin : g_off
    assign mis1 = |p1.addr[OFF_W-1:0];
    assign mis2 = |p2.addr[OFF_W-1:0];
  end else begin : g_no_off
    assign mis1 = 1'b0;
    assign mis2 = 1'b0;
  end

  // Address bits above the word index only wrap the address space.
  logic unused_addr;
  assign unused_addr = ^{p1.addr, p2.addr};

  logic active;
  logic rd1, wr1, er1, rd2, wr2, er2;

  assign active = (state_reg == READY);
  assign rd1 = active & p1.req & ~p1.we & ~mis1;
  assign wr1 = active & p1.req &  p1.we & ~mis1;
  assign er1 = active & p1.req &  mis1;
  assign rd2 = active & p2.req & ~p2.we & ~mis2;
  assign wr2 = active & p2.req &  p2.we & ~mis2;
  assign er2 = active & p2.req &  mis2;

  // ----------------------------------------------------- byte-lane RAMs
  logic [DATA_W-1:0] rdata1_w, rdata2_w;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [7:0] INIT_BYTE = INIT_WORD[gi*8 +: 8];

    logic [7:0] mem_reg [DEPTH];
    logic [7:0] q1_reg, q2_reg;

    // Port 1 is written last so it wins a lane both ports enable on the
    // same word; nothing is written while reset is held.
    always_ff @(posedge m_clock) begin
      if (p_reset) begin
        if (state_reg == INIT) begin
          mem_reg[cnt_reg] <= INIT_BYTE;
        end else begin
          if (wr2 && p2.be[gi]) mem_reg[idx2] <= p2.wdata[gi*8 +: 8];
          if (wr1 && p1.be[gi]) mem_reg[idx1] <= p1.wdata[gi*8 +: 8];
        end
      end
    end

    // Registered reads sample the array before this edge's writes land,
    // which gives old data on a same-cycle cross-port collision.
    always_ff @(posedge m_clock) begin
      if (!p_reset) begin
        q1_reg <= '0;
        q2_reg <= '0;
      end else begin
        if (rd1)      q1_reg <= mem_reg[idx1];
        else if (er1) q1_reg <= '0;
        if (rd2)      q2_reg <= mem_reg[idx2];
        else if (er2) q2_reg <= '0;
      end
    end

    assign rdata1_w[gi*8 +: 8] = q1_reg;
    assign rdata2_w[gi*8 +: 8] = q2_reg;
  end

  // --------------------------------------------------- response pulses
  logic rvalid1_reg, err1_reg, rvalid2_reg, err2_reg;

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      rvalid1_reg <= 1'b0;
      err1_reg    <= 1'b0;
      rvalid2_reg <= 1'b0;
      err2_reg    <= 1'b0;
    end else begin
      rvalid1_reg <= rd1;
      err1_reg    <= er1;
      rvalid2_reg <= rd2;
      err2_reg    <= er2;
    end
  end

  assign p1.rdata  = rdata1_w;
  assign p1.rvalid = rvalid1_reg;
  assign p1.err    = err1_reg;
  assign p2.rdata  = rdata2_w;
  assign p2.rvalid = rvalid2_reg;
  assign p2.err    = err2_reg;

endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be -- directed bench for dpram_be (DATA_W=32, DEPTH=1024).
// Stimulus pushes expected responses into per-port queues; a negedge
// monitor pops and compares whenever a port shows rvalid or err, and flags
// responses that are missing or unexpected.
module tb_dpram_be;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic m_clock = 1'b0;
  logic p_reset = 1'b0;
  logic busy;

  dpram_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p1_if ();
  dpram_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p2_if ();

  dpram_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .p1      (p1_if),
    .p2      (p2_if),
    .busy    (busy)
  );

  always #5 m_clock = ~m_clock;

  int cyc = 0;
  always @(posedge m_clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    int          kind;   // 1 = read data, 2 = error
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic check_resp(input string port, input exp_t e, input logic rv,
                            input logic er, input logic [31:0] rd);
    logic [31:0] flags_exp;
    flags_exp = (e.kind == 1) ? 32'd2 : 32'd1;
    chk({port, " ", e.name, " flags{rvalid,err}"}, {30'b0, rv, er}, flags_exp);
    chk({port, " ", e.name, " rdata"}, rd, e.data);
    chk({port, " ", e.name, " cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: compare on every response, catch missing and stray ones.
  always @(negedge m_clock) begin
    exp_t e;
    if (p1_if.rvalid === 1'b1 || p1_if.err === 1'b1) begin
      if (q1.size() == 0) chk("p1 unexpected response", {30'b0, p1_if.rvalid, p1_if.err}, 32'd0);
      else begin
        e = q1.pop_front();
        check_resp("p1", e, p1_if.rvalid, p1_if.err, p1_if.rdata);
      end
    end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      chk({"p1 ", e.name, " missing response"}, 32'd0, 32'd1);
    end
    if (p2_if.rvalid === 1'b1 || p2_if.err === 1'b1) begin
      if (q2.size() == 0) chk("p2 unexpected response", {30'b0, p2_if.rvalid, p2_if.err}, 32'd0);
      else begin
        e = q2.pop_front();
        check_resp("p2", e, p2_if.rvalid, p2_if.err, p2_if.rdata);
      end
    end else if (q2.size() > 0 && q2[0].cyc <= cyc) begin
      e = q2.pop_front();
      chk({"p2 ", e.name, " missing response"}, 32'd0, 32'd1);
    end
  end

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic idle();
    tick();
    p1_if.req = 1'b0;
    p2_if.req = 1'b0;
  endtask

  // Drive one port for the coming edge; k selects the expected response.
  task automatic set_p(input int port, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input int k, input logic [31:0] e, input string n);
    exp_t x;
    if (port == 1) begin
      p1_if.req = 1'b1; p1_if.we = w; p1_if.be = b; p1_if.addr = a; p1_if.wdata = d;
    end else begin
      p2_if.req = 1'b1; p2_if.we = w; p2_if.be = b; p2_if.addr = a; p2_if.wdata = d;
    end
    x.cyc = cyc + 1; x.kind = k; x.data = e; x.name = n;
    if (k != 0) begin
      if (port == 1) q1.push_back(x);
      else           q2.push_back(x);
    end
    $display("[TB] cyc %0d p%0d %s addr=0x%08h be=%b wdata=0x%08h (%s)",
             cyc, port, w ? "WR" : "RD", a, b, d, n);
  endtask

  // Count edges from release until busy drops; requests stay as driven.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 2000);
    p1_if.req = 1'b0;
    p2_if.req = 1'b0;
    chk(name, 32'(n), 32'd1024);
  endtask

  initial begin
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.be = '0; p1_if.addr = '0; p1_if.wdata = '0;
    p2_if.req = 1'b0; p2_if.we = 1'b0; p2_if.be = '0; p2_if.addr = '0; p2_if.wdata = '0;

    // Reset state
    repeat (3) tick();
    chk("reset busy",    {31'b0, busy}, 32'd1);
    chk("reset rvalid1", {31'b0, p1_if.rvalid}, 32'd0);
    chk("reset err1",    {31'b0, p1_if.err}, 32'd0);
    chk("reset rdata1",  p1_if.rdata, 32'd0);
    chk("reset rdata2",  p2_if.rdata, 32'd0);

    // Initialisation length
    tick(); p_reset = 1'b1;
    wait_init("init busy cycles");

    // Init contents, including the wrapped address 0x1000
    idle(); set_p(1, 0, 4'h0, 32'h0000_0000, 0, 1, 32'h0000_0013, "init rd 0x0");
    idle(); set_p(1, 0, 4'h0, 32'h0000_0FFC, 0, 1, 32'h0000_0013, "init rd 0xFFC");
    idle(); set_p(1, 0, 4'h0, 32'h0000_1000, 0, 1, 32'h0000_0013, "init rd 0x1000");

    // Byte enables
    idle(); set_p(1, 1, 4'b0101, 32'h10, 32'hAABB_CCDD, 0, 0, "be write 0x10");
    idle(); set_p(1, 0, 4'h0, 32'h10, 0, 1, 32'h00BB_00DD, "be read 0x10");
    idle(); set_p(2, 0, 4'h0, 32'h1010, 0, 1, 32'h00BB_00DD, "alias read 0x1010");

    // Same-word write collision
    idle(); set_p(1, 1, 4'b0011, 32'h20, 32'h1111_1111, 0, 0, "collide wr p1");
            set_p(2, 1, 4'b1110, 32'h20, 32'h2222_2222, 0, 0, "collide wr p2");
    idle(); set_p(1, 0, 4'h0, 32'h20, 0, 1, 32'h2222_1111, "collide rd p1");
            set_p(2, 0, 4'h0, 32'h20, 0, 1, 32'h2222_1111, "collide rd p2");

    // Read-first across ports
    idle(); set_p(1, 1, 4'hF, 32'h30, 32'hDEAD_BEEF, 0, 0, "rf write 0x30");
            set_p(2, 0, 4'h0, 32'h30, 0, 1, 32'h0000_0013, "rf read old 0x30");
    idle(); set_p(2, 0, 4'h0, 32'h30, 0, 1, 32'hDEAD_BEEF, "rf read new 0x30");

    // Misalignment on both ports
    idle(); set_p(2, 0, 4'h0, 32'h41, 0, 2, 0, "misaligned rd 0x41");
    idle(); set_p(2, 1, 4'hF, 32'h42, 32'hFFFF_FFFF, 2, 0, "misaligned wr 0x42");
    idle(); set_p(2, 0, 4'h0, 32'h40, 0, 1, 32'h0000_0013, "rd 0x40 unchanged");
    idle(); set_p(1, 0, 4'h0, 32'h13, 0, 2, 0, "misaligned rd p1 0x13");

    // Write with no lanes enabled, and a single top-lane write on port 2
    idle(); set_p(2, 1, 4'b0000, 32'h50, 32'hFFFF_FFFF, 0, 0, "no-lane wr 0x50");
            set_p(1, 1, 4'b1000, 32'h60, 32'hA5A5_A5A5, 0, 0, "lane3 wr 0x60");
    idle(); set_p(2, 0, 4'h0, 32'h50, 0, 1, 32'h0000_0013, "rd 0x50");
            set_p(1, 0, 4'h0, 32'h60, 0, 1, 32'hA500_0013, "rd 0x60");

    // Read data holds across idle cycles and writes
    idle(); set_p(1, 1, 4'hF, 32'h10, 32'h0, 0, 0, "wr 0x10 zero");
    idle(); idle(); idle();
    chk("rdata1 hold", p1_if.rdata, 32'hA500_0013);
    chk("rdata2 hold", p2_if.rdata, 32'h0000_0013);

    // Reset mid-INIT with requests held active throughout
    tick(); p_reset = 1'b0;
    tick(); tick();
    chk("reset2 rdata1", p1_if.rdata, 32'd0);
    tick(); p_reset = 1'b1;
    set_p(1, 0, 4'h0, 32'h0, 0, 0, 0, "rd during busy");
    set_p(2, 0, 4'h0, 32'h41, 0, 0, 0, "misaligned rd during busy");
    repeat (500) tick();
    p_reset = 1'b0;
    tick(); tick();
    chk("mid-init reset busy", {31'b0, busy}, 32'd1);
    p_reset = 1'b1;
    wait_init("re-init busy cycles");
    idle(); set_p(1, 0, 4'h0, 32'h10, 0, 1, 32'h0000_0013, "re-init rd 0x10");
            set_p(2, 0, 4'h0, 32'h30, 0, 1, 32'h0000_0013, "re-init rd 0x30");

    repeat (4) idle();
    chk("p1 queue drained", 32'(q1.size()), 32'd0);
    chk("p2 queue drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
